// File: rtl/alu_issue.sv
// Issue/writeback stage in front of a DSP48E1 ALU core: decodes instructions into
// core operands/controls, tracks busy registers, and writes P back ALU_LAT cycles later.
module alu_issue #(
    parameter int ALU_LAT = 4,
    parameter int NREG    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic        ld_valid_i,
    input  logic [3:0]  ld_addr_i,
    input  logic [47:0] ld_data_i,
    output logic        ld_ready_o,
    output logic [29:0] a_o,
    output logic [17:0] b_o,
    output logic [47:0] c_o,
    output logic [3:0]  alumode_o,
    output logic [6:0]  opmode_o,
    output logic [4:0]  inmode_o,
    output logic        usemult_o,
    input  logic [47:0] p_i,
    output logic        wb_valid_o,
    output logic [3:0]  wb_addr_o,
    output logic [47:0] wb_data_o
);

    logic [47:0]      rf_r [NREG];
    logic [NREG-1:0]  busy_r;
    logic [ALU_LAT-1:0] pv_r;
    logic [3:0]       prd_r [ALU_LAT];

    logic [3:0] op_s, rd_s, ra_s, rb_s, rc_s;
    logic [6:0] opmode_s;
    logic [3:0] alumode_s;
    logic       usemult_s, use_rb_s, use_rc_s, wr_s;
    logic       hazard_s, issue_s, ld_acc_s;
    logic       unused_s;

    assign op_s = instr_i[23:20];
    assign rd_s = instr_i[19:16];
    assign ra_s = instr_i[15:12];
    assign rb_s = instr_i[11:8];
    assign rc_s = instr_i[7:4];
    assign unused_s = ^instr_i[3:0];

    // Opcode decode into core controls and the set of source registers used
    always_comb begin
        opmode_s  = 7'b0000000;
        alumode_s = 4'b0000;
        usemult_s = 1'b0;
        use_rb_s  = 1'b0;
        use_rc_s  = 1'b0;
        wr_s      = 1'b0;
        case (op_s)
            4'd1: begin opmode_s = 7'b0110011; alumode_s = 4'b0000; use_rc_s = 1'b1; wr_s = 1'b1; end
            4'd2: begin opmode_s = 7'b0110011; alumode_s = 4'b0011; use_rc_s = 1'b1; wr_s = 1'b1; end
            4'd3: begin opmode_s = 7'b0000101; usemult_s = 1'b1; use_rb_s = 1'b1; wr_s = 1'b1; end
            4'd4: begin
                opmode_s  = 7'b0110101;
                usemult_s = 1'b1;
                use_rb_s  = 1'b1;
                use_rc_s  = 1'b1;
                wr_s      = 1'b1;
            end
            4'd5: begin opmode_s = 7'b0110011; alumode_s = 4'b1100; use_rc_s = 1'b1; wr_s = 1'b1; end
            4'd6: begin opmode_s = 7'b0111011; alumode_s = 4'b1100; use_rc_s = 1'b1; wr_s = 1'b1; end
            4'd7: begin opmode_s = 7'b0110011; alumode_s = 4'b0100; use_rc_s = 1'b1; wr_s = 1'b1; end
            default: begin
                opmode_s  = 7'b0000000;
                alumode_s = 4'b0000;
            end
        endcase
    end

    // Hazard check; ra is a source of every writing op, rd is checked for WAW
    always_comb begin
        hazard_s = (wr_s & busy_r[ra_s]) | (use_rb_s & busy_r[rb_s]) |
                   (use_rc_s & busy_r[rc_s]) | (wr_s & busy_r[rd_s]);
    end

    assign issue_s       = rst_n & instr_valid_i & ~ld_valid_i & ~hazard_s;
    assign instr_ready_o = issue_s;
    assign ld_ready_o    = rst_n & ~busy_r[ld_addr_i];
    assign ld_acc_s      = ld_valid_i & ld_ready_o;

    // Operand and control drive, only during the issue cycle
    always_comb begin
        a_o       = 30'h0;
        b_o       = 18'h0;
        c_o       = 48'h0;
        opmode_o  = 7'b0000000;
        alumode_o = 4'b0000;
        usemult_o = 1'b0;
        inmode_o  = 5'b00000;
        if (issue_s) begin
            if (usemult_s) begin
                a_o = {{5{rf_r[ra_s][24]}}, rf_r[ra_s][24:0]};
                b_o = rf_r[rb_s][17:0];
            end else if (wr_s) begin
                {a_o, b_o} = rf_r[ra_s];
            end else begin
                a_o = 30'h0;
                b_o = 18'h0;
            end
            c_o       = use_rc_s ? rf_r[rc_s] : 48'h0;
            opmode_o  = opmode_s;
            alumode_o = alumode_s;
            usemult_o = usemult_s;
        end else begin
            c_o = 48'h0;
        end
    end

    // Latency pipe carrying {valid, rd} from issue to writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= '0;
            for (int i = 0; i < ALU_LAT; i++) prd_r[i] <= 4'h0;
        end else begin
            pv_r     <= {pv_r[ALU_LAT-2:0], issue_s & wr_s};
            prd_r[0] <= rd_s;
            for (int i = 1; i < ALU_LAT; i++) prd_r[i] <= prd_r[i-1];
        end
    end

    assign wb_valid_o = pv_r[ALU_LAT-1];
    assign wb_addr_o  = prd_r[ALU_LAT-1];
    assign wb_data_o  = p_i;

    // Busy scoreboard; a set and a clear never target the same bit on one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (issue_s && wr_s && (rd_s == 4'(i))) begin
                    busy_r[i] <= 1'b1;
                end else if (wb_valid_o && (wb_addr_o == 4'(i))) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

    // Register file: writeback and host load hit different registers by construction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_r[i] <= 48'h0;
        end else begin
            if (wb_valid_o) rf_r[wb_addr_o] <= p_i;
            if (ld_acc_s) rf_r[ld_addr_i] <= ld_data_i;
        end
    end

endmodule
